if_next_pc_btb: RTL and testbench

//  IF-stage next-PC unit: PC register, direct-mapped branch target buffer (BTB), IF->ID prediction tracking.

---
 rtl/if_next_pc_btb.sv | 146 ++++++++++++++
 tb/tb_if_next_pc_btb.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_next_pc_btb.sv
// +----------------------------------------------------------------------------+
// | Module      : if_next_pc_btb                                               |
// | Description : IF-stage next-PC unit with a direct-mapped BTB and IF->ID    |
// |               prediction tracking; detects mispredicts when ID resolves.   |
// | Option      : BTB_BYPASS_EN - forward a same-cycle BTB write into lookup.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module if_next_pc_btb #(
    parameter int                ADDR_W      = 32,
    parameter int                BTB_ENTRIES = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_if,
    input  logic              predict_br_taken,
    input  logic              brch_instr_detectd_ID,
    input  logic              brch_hazard_stall,
    input  logic              actual_brch_result,
    input  logic [ADDR_W-1:0] brch_target_ID,
    output logic [ADDR_W-1:0] pc_IF,
    output logic              btb_hit_IF,
    output logic              pred_taken_ID,
    output logic              mispredict_flush
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [ADDR_W-1:0] C_PC_STEP = ADDR_W'(4);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_id_q, pc_id_d;
    logic [ADDR_W-1:0] pred_tgt_q, pred_tgt_d;
    logic              pred_taken_q, pred_taken_d;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
    logic [ADDR_W-1:0]      tgt_q [BTB_ENTRIES];

    logic [IDX_W-1:0]  lk_idx, wr_idx;
    logic [TAG_W-1:0]  lk_tag, wr_tag;
    logic [ADDR_W-1:0] lk_tgt;
    logic              lk_hit;
    logic              eff_pred;
    logic              resolve;
    logic              wr_en;
    logic              flush;

    assign lk_idx = pc_q[IDX_W+1:2];
    assign lk_tag = pc_q[ADDR_W-1:IDX_W+2];
    assign wr_idx = pc_id_q[IDX_W+1:2];
    assign wr_tag = pc_id_q[ADDR_W-1:IDX_W+2];

    assign resolve = brch_instr_detectd_ID & ~brch_hazard_stall;
    // Only taken resolutions allocate; reset blocks the write so a held reset is inert.
    assign wr_en   = rst_n & resolve & actual_brch_result;

    always_comb begin
        lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_tgt = tgt_q[lk_idx];
`ifdef BTB_BYPASS_EN
        if (wr_en && (wr_idx == lk_idx)) begin
            lk_hit = (wr_tag == lk_tag);
            lk_tgt = brch_target_ID;
        end
`endif
    end

    assign eff_pred = predict_br_taken & lk_hit;

    always_comb begin
        flush = 1'b0;
        if (rst_n && resolve) begin
            if (actual_brch_result) begin
                flush = ~pred_taken_q | (pred_tgt_q != brch_target_ID);
            end else begin
                flush = pred_taken_q;
            end
        end
    end

    always_comb begin
        pc_d         = pc_q + C_PC_STEP;
        pc_id_d      = pc_id_q;
        pred_tgt_d   = pred_tgt_q;
        pred_taken_d = pred_taken_q;

        if (flush) begin
            pc_d = actual_brch_result ? brch_target_ID : (pc_id_q + C_PC_STEP);
        end else if (stall_if) begin
            pc_d = pc_q;
        end else if (eff_pred) begin
            pc_d = lk_tgt;
        end

        if (!stall_if) begin
            pc_id_d      = pc_q;
            pred_tgt_d   = lk_tgt;
            pred_taken_d = eff_pred;
        end
        // A flushed slot becomes a bubble regardless of stall.
        if (flush) begin
            pred_taken_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            pc_id_q      <= {ADDR_W{1'b0}};
            pred_tgt_q   <= {ADDR_W{1'b0}};
            pred_taken_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pc_id_q      <= pc_id_d;
            pred_tgt_q   <= pred_tgt_d;
            pred_taken_q <= pred_taken_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= {BTB_ENTRIES{1'b0}};
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag/target storage carries no reset; entries are gated by valid_q.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx] <= wr_tag;
            tgt_q[wr_idx] <= brch_target_ID;
        end
    end

    assign pc_IF            = pc_q;
    assign btb_hit_IF       = lk_hit;
    assign pred_taken_ID    = pred_taken_q;
    assign mispredict_flush = flush;

endmodule

`default_nettype wire

// File: tb/tb_if_next_pc_btb.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_if_next_pc_btb                                            |
// | Description : Directed scenarios plus randomized traffic for               |
// |               if_next_pc_btb, checked against a behavioural model.         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_if_next_pc_btb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_if;
    logic        predict_br_taken;
    logic        brch_instr_detectd_ID;
    logic        brch_hazard_stall;
    logic        actual_brch_result;
    logic [31:0] brch_target_ID;
    logic [31:0] pc_IF;
    logic        btb_hit_IF;
    logic        pred_taken_ID;
    logic        mispredict_flush;

    int n_cmp = 0;
    int n_mis = 0;

    // Behavioural model: PC, IF->ID slot and a table of 16 entries indexed by word address.
    bit [31:0]   m_pc    = 32'h0;
    bit [31:0]   m_pcid  = 32'h0;
    bit [31:0]   m_tgtid = 32'h0;
    bit          m_pred  = 1'b0;
    bit          m_val [16];
    int unsigned m_tagv[16];
    bit [31:0]   m_dst [16];

    if_next_pc_btb #(
        .ADDR_W     (32),
        .BTB_ENTRIES(16),
        .RESET_PC   (32'h0)
    ) u_dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .stall_if             (stall_if),
        .predict_br_taken     (predict_br_taken),
        .brch_instr_detectd_ID(brch_instr_detectd_ID),
        .brch_hazard_stall    (brch_hazard_stall),
        .actual_brch_result   (actual_brch_result),
        .brch_target_ID       (brch_target_ID),
        .pc_IF                (pc_IF),
        .btb_hit_IF           (btb_hit_IF),
        .pred_taken_ID        (pred_taken_ID),
        .mispredict_flush     (mispredict_flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rst_n                 = 1'b1;
        stall_if              = 1'b0;
        predict_br_taken      = 1'b0;
        brch_instr_detectd_ID = 1'b0;
        brch_hazard_stall     = 1'b0;
        actual_brch_result    = 1'b0;
        brch_target_ID        = 32'h0;
    endtask

    // Called at the negedge with inputs applied: checks outputs, then advances one clock.
    task automatic step();
        int        li, wi;
        bit        hit, res, fl, wr, eff;
        bit [31:0] btgt, nxt;
        li   = int'((m_pc / 4) % 16);
        wi   = int'((m_pcid / 4) % 16);
        res  = brch_instr_detectd_ID && !brch_hazard_stall;
        wr   = rst_n && res && actual_brch_result;
        hit  = m_val[li] && (m_tagv[li] == m_pc / 64);
        btgt = m_dst[li];
`ifdef BTB_BYPASS_EN
        if (wr && wi == li) begin
            hit  = (m_pcid / 64 == m_pc / 64);
            btgt = brch_target_ID;
        end
`endif
        eff = predict_br_taken && hit;
        if (!rst_n || !res)           fl = 1'b0;
        else if (actual_brch_result)  fl = !m_pred || (m_tgtid != brch_target_ID);
        else                          fl = m_pred;
        if (fl)              nxt = actual_brch_result ? brch_target_ID : m_pcid + 32'd4;
        else if (stall_if)   nxt = m_pc;
        else if (eff)        nxt = btgt;
        else                 nxt = m_pc + 32'd4;

        #1;
        check("pc_IF", pc_IF, m_pc);
        check("btb_hit_IF", {31'b0, btb_hit_IF}, {31'b0, hit});
        check("pred_taken_ID", {31'b0, pred_taken_ID}, {31'b0, m_pred});
        check("mispredict_flush", {31'b0, mispredict_flush}, {31'b0, fl});

        @(posedge clk);
        if (!rst_n) begin
            m_pc = 32'h0; m_pcid = 32'h0; m_tgtid = 32'h0; m_pred = 1'b0;
            for (int i = 0; i < 16; i++) m_val[i] = 1'b0;
        end else begin
            if (wr) begin
                m_val[wi]  = 1'b1;
                m_tagv[wi] = m_pcid / 64;
                m_dst[wi]  = brch_target_ID;
            end
            if (!stall_if) begin
                m_pcid  = m_pc;
                m_tgtid = btgt;
                m_pred  = eff;
            end
            if (fl) m_pred = 1'b0;
            m_pc = nxt;
        end
        @(negedge clk);
    endtask

    task automatic run_to(input bit [31:0] addr);
        int guard = 0;
        idle_inputs();
        while (m_pc != addr && guard < 200) begin
            step();
            guard++;
        end
        check("run_to_reached", pc_IF, addr);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_val[i] = 1'b0; m_tagv[i] = 0; m_dst[i] = 32'h0;
        end
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state and sequential fetch
        #1;
        check("rst_pc", pc_IF, 32'h0);
        check("rst_hit", {31'b0, btb_hit_IF}, 32'h0);
        check("rst_flush", {31'b0, mispredict_flush}, 32'h0);
        check("rst_pred", {31'b0, pred_taken_ID}, 32'h0);
        step();
        check("seq_pc4", pc_IF, 32'h4);
        step();
        check("seq_pc8", pc_IF, 32'h8);

        // Cold branch at 0x40 resolves taken to 0x100
        run_to(32'h40);
        step();
        brch_instr_detectd_ID = 1'b1; actual_brch_result = 1'b1; brch_target_ID = 32'h100;
        #1 check("cold_flush", {31'b0, mispredict_flush}, 32'h1);
        step();
        idle_inputs();
        #1 check("cold_redirect", pc_IF, 32'h100);

        // Return to 0x40, then predicted-taken hit resolving correctly
        brch_instr_detectd_ID = 1'b1; actual_brch_result = 1'b1; brch_target_ID = 32'h40;
        step();
        idle_inputs();
        predict_br_taken = 1'b1;
        #1 check("warm_hit", {31'b0, btb_hit_IF}, 32'h1);
        step();
        idle_inputs();
        #1 check("warm_pc", pc_IF, 32'h100);
        check("warm_pred_ID", {31'b0, pred_taken_ID}, 32'h1);
        brch_instr_detectd_ID = 1'b1; actual_brch_result = 1'b1; brch_target_ID = 32'h100;
        #1 check("warm_no_flush", {31'b0, mispredict_flush}, 32'h0);
        step();
        idle_inputs();
        #1 check("warm_next", pc_IF, 32'h104);

        // Predicted taken at 0x40 resolves not taken
        step();
        brch_instr_detectd_ID = 1'b1; actual_brch_result = 1'b1; brch_target_ID = 32'h40;
        step();
        idle_inputs();
        predict_br_taken = 1'b1;
        step();
        idle_inputs();
        brch_instr_detectd_ID = 1'b1; actual_brch_result = 1'b0;
        #1 check("nt_flush", {31'b0, mispredict_flush}, 32'h1);
        step();
        idle_inputs();
        #1 check("nt_fallthrough", pc_IF, 32'h44);

        // Alias at 0x80 shares index 0 with a different tag
        run_to(32'h80);
        predict_br_taken = 1'b1;
        #1 check("alias_hit", {31'b0, btb_hit_IF}, 32'h0);
        step();
        idle_inputs();
        #1 check("alias_pc", pc_IF, 32'h84);
        check("alias_pred_ID", {31'b0, pred_taken_ID}, 32'h0);

        // Stall hold, hazard-blocked resolve, then flush during stall
        rst_n = 1'b0;
        step();
        step();
        run_to(32'h20);
        stall_if = 1'b1; brch_instr_detectd_ID = 1'b1; brch_hazard_stall = 1'b1;
        actual_brch_result = 1'b1; brch_target_ID = 32'h200;
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_hold", pc_IF, 32'h20);
            check("hazard_no_flush", {31'b0, mispredict_flush}, 32'h0);
            step();
        end
        brch_hazard_stall = 1'b0;
        #1 check("stall_flush", {31'b0, mispredict_flush}, 32'h1);
        step();
        idle_inputs();
        #1 check("stall_redirect", pc_IF, 32'h200);
        check("stall_bubble", {31'b0, pred_taken_ID}, 32'h0);

        // Randomized traffic over a small address window so entries alias and re-hit
        for (int n = 0; n < 3000; n++) begin
            rst_n                 = ($urandom_range(0, 99) != 0);
            stall_if              = ($urandom_range(0, 4) == 0);
            predict_br_taken      = ($urandom_range(0, 9) < 6);
            brch_instr_detectd_ID = ($urandom_range(0, 9) < 4);
            brch_hazard_stall     = ($urandom_range(0, 4) == 0);
            actual_brch_result    = $urandom_range(0, 1) != 0;
            brch_target_ID        = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
